// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive path.
// Optional 8E1 framing is selected with RX_PIPE_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE = 1'b1;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_pipe_if.sv
// Core-facing bundle of the receive pipe: serial pin in,
// FIFO head out with pop_front/empty handshake.
interface rx_pipe_if;
  logic       rx;
  logic       pop_front;
  logic [7:0] data_out;
  logic       empty;
  logic       error;

  modport master (
    output rx,
    output pop_front,
    input  data_out,
    input  empty,
    input  error
  );

  modport slave (
    input  rx,
    input  pop_front,
    output data_out,
    output empty,
    output error
  );
endinterface

// File: rtl/uart_rx.sv
// UART frame deserialiser: synchroniser, bit FSM, shift register.
// RX_PIPE_PARITY_EN adds an even-parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF_T =
    (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;

  rx_state_t state, state_n;

  logic          s1, rx_s, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  logic          fall;
  logic          last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= UART_IDLE;
      rx_s    <= UART_IDLE;
      rx_prev <= UART_IDLE;
    end else begin
      s1      <= rx;
      rx_s    <= s1;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;
  assign last_bit =
    (bit_idx == 3'(UART_DATA_BITS - 1));

  always_comb begin
    if (state == START)
      tick = (cnt == CW'(HALF_T));
    else
      tick = (cnt == CW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (fall) state_n = START;
      START:
        if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (tick && last_bit) begin
`ifdef RX_PIPE_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      PARITY:
        if (tick) state_n = STOP;
      STOP:
        if (tick) state_n = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH:
        if (rx_s) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

`ifdef RX_PIPE_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perr_q <= 1'b0;
    else if (state == IDLE)
      perr_q <= 1'b0;
    else if (state == PARITY && tick)
      perr_q <= ^{shreg, rx_s};
  end
`else
  logic perr_q;
  assign perr_q = 1'b0;
`endif

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    if (state == STOP && tick) begin
      byte_valid = rx_s & ~perr_q;
      frame_err  = ~rx_s;
      parity_err = perr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (state == IDLE)
        bit_idx <= '0;
      else if (state == DATA && tick) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {rx_s, shreg[7:1]};
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/rx_pipe.sv
// UART receiver with first-word fall-through byte FIFO.
// Build with RX_PIPE_PARITY_EN for 8E1 frames.
module rx_pipe
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 9_600,
  parameter int DEPTH    = 16
) (
  input logic clk,
  input logic rst,
  rx_pipe_if.slave bus
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int AW  = $clog2(DEPTH);

  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          frame_err;
  logic          parity_err;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          empty, full;
  logic          do_push, do_pop, overrun;
  logic          error_q;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (bus.rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot, so a push into a full FIFO is legal that cycle.
  assign do_pop  = bus.pop_front & ~empty;
  assign do_push = byte_valid & (~full | do_pop);
  assign overrun = byte_valid & full & ~do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      error_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (frame_err | parity_err | overrun)
        error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  assign bus.empty    = empty;
  assign bus.error    = error_q;
  assign bus.data_out =
    empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_rx_pipe.sv
// Directed bench for rx_pipe, scaled to 16 clocks per bit.
// Define RX_PIPE_PARITY_EN on both bench and RTL for 8E1.
module tb_rx_pipe;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  rx_pipe_if intf ();

  rx_pipe #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_bit();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_head(
    input logic [7:0] d,
    input logic       pflip
  );
    intf.rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      intf.rx = d[i];
      wait_bit();
    end
`ifdef RX_PIPE_PARITY_EN
    intf.rx = (^d) ^ pflip;
    wait_bit();
`else
    if (pflip) $display("note: parity ignored in 8N1");
`endif
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop,
    input logic       pflip
  );
    send_head(d, pflip);
    intf.rx = stop;
    wait_bit();
  endtask

  task automatic pop1();
    intf.pop_front = 1'b1;
    @(negedge clk);
    intf.pop_front = 1'b0;
  endtask

  initial begin
    intf.rx        = 1'b1;
    intf.pop_front = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", 8'(intf.empty), 8'h01);
    check("rst_data", intf.data_out, 8'h00);
    check("rst_error", 8'(intf.error), 8'h00);
    rst = 1'b0;
    wait_bit();

    // Frame 'H', watch empty fall during the stop bit
    send_head(8'h48, 1'b0);
    intf.rx = 1'b1;
    repeat (4) @(negedge clk);
    check("h_pre_empty", 8'(intf.empty), 8'h01);
    repeat (12) @(negedge clk);
    check("h_empty", 8'(intf.empty), 8'h00);
    check("h_data", intf.data_out, 8'h48);
    check("h_error", 8'(intf.error), 8'h00);
    pop1();
    check("h_pop_empty", 8'(intf.empty), 8'h01);
    check("h_pop_data", intf.data_out, 8'h00);

    // Short glitch shorter than half a bit
    intf.rx = 1'b0;
    repeat (4) @(negedge clk);
    intf.rx = 1'b1;
    wait_bit();
    wait_bit();
    check("gl_empty", 8'(intf.empty), 8'h01);
    check("gl_error", 8'(intf.error), 8'h00);
    send_frame(8'h33, 1'b1, 1'b0);
    wait_bit();
    check("gl_next", intf.data_out, 8'h33);
    pop1();

    // Framing error followed by a break
    send_frame(8'h61, 1'b0, 1'b0);
    repeat (3) wait_bit();
    check("fe_error", 8'(intf.error), 8'h01);
    check("fe_empty", 8'(intf.empty), 8'h01);
    intf.rx = 1'b1;
    wait_bit();
    send_frame(8'h6C, 1'b1, 1'b0);
    wait_bit();
    check("fe_next_empty", 8'(intf.empty), 8'h00);
    check("fe_next_data", intf.data_out, 8'h6C);
    pop1();

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_error", 8'(intf.error), 8'h00);
    wait_bit();

    // Fill 16 entries, then overrun with the 17th
    for (int i = 0; i < 16; i++)
      send_frame(8'(i), 1'b1, 1'b0);
    wait_bit();
    check("full_error", 8'(intf.error), 8'h00);
    check("full_head", intf.data_out, 8'h00);
    send_frame(8'h10, 1'b1, 1'b0);
    wait_bit();
    check("ovr_error", 8'(intf.error), 8'h01);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_pop%0d", i),
            intf.data_out, 8'(i));
      pop1();
    end
    check("ovr_empty", 8'(intf.empty), 8'h01);
    check("ovr_data0", intf.data_out, 8'h00);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_bit();
    check("pre_rst_empty", 8'(intf.empty), 8'h00);
    intf.rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      intf.rx = i[0];
      wait_bit();
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_empty", 8'(intf.empty), 8'h01);
    check("mid_rst_data", intf.data_out, 8'h00);
    check("mid_rst_error", 8'(intf.error), 8'h00);
    intf.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_bit();
    wait_bit();
    send_frame(8'h0A, 1'b1, 1'b0);
    wait_bit();
    check("post_rst_data", intf.data_out, 8'h0A);
    check("post_rst_err", 8'(intf.error), 8'h00);
    pop1();

`ifdef RX_PIPE_PARITY_EN
    send_frame(8'h6F, 1'b1, 1'b1);
    wait_bit();
    check("par_bad_error", 8'(intf.error), 8'h01);
    check("par_bad_empty", 8'(intf.empty), 8'h01);
    send_frame(8'h6F, 1'b1, 1'b0);
    wait_bit();
    check("par_ok_data", intf.data_out, 8'h6F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
